// File: rtl/fx_pkg.sv
// Shared state encoding and control-to-shift/arithmetic helpers for the fx_compressor_mc slice.
package fx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DETECT,
        S_ENV,
        S_DIV,
        S_APPLY
    } state_t;

    // Unity gain in Q1.(gain_w-1).
    function automatic longint unsigned gain_one(input int unsigned gain_w);
        return 64'd1 << (gain_w - 1);
    endfunction

    function automatic logic [3:0] ar_shift(input int unsigned ctrl, input int unsigned param_w);
        return 4'(ctrl >> (param_w - 4));
    endfunction

    function automatic logic [2:0] ratio_shift(input int unsigned ctrl, input int unsigned param_w);
        return 3'(ctrl >> (param_w - 3));
    endfunction

    function automatic longint unsigned thr_scale(input int unsigned ctrl, input int unsigned param_w,
                                                  input int unsigned data_w);
        return 64'(ctrl) << (data_w - 1 - param_w);
    endfunction

    // |x| clamped to the largest positive value of a data_w-bit signed sample.
    function automatic longint unsigned sat_abs(input longint x, input int unsigned data_w);
        longint unsigned mag;
        longint unsigned lim;
        lim = (64'd1 << (data_w - 1)) - 64'd1;
        mag = (x < 0) ? 64'(-x) : 64'(x);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/fx_compressor_mc_if.sv
// Frame streaming interface of fx_compressor_mc: input strobe/frame, busy, output pulse/frame.
interface fx_compressor_mc_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 2
);
    logic                           in_valid;
    logic [NUM_CH-1:0][DATA_W-1:0]  audio_in;
    logic                           busy;
    logic                           out_valid;
    logic [NUM_CH-1:0][DATA_W-1:0]  audio_out;

    modport master (output in_valid, audio_in, input busy, out_valid, audio_out);
    modport slave  (input in_valid, audio_in, output busy, out_valid, audio_out);
endinterface

// File: rtl/fx_udiv.sv
// Sequential restoring divider: quot = num / den in exactly Q_W cycles after start.
// Caller guarantees num < (den << Q_W), so the quotient fits in Q_W bits.
module fx_udiv #(
    parameter int unsigned NUM_W = 30,
    parameter int unsigned DEN_W = 15,
    parameter int unsigned Q_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [Q_W-1:0]   quot,
    output logic             done
);
    localparam int unsigned CNT_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den_q;
    logic [Q_W-1:0]   num_lo;
    logic [CNT_W-1:0] cnt;
    logic [DEN_W:0]   trial;
    logic             fits;

    always_comb begin
        trial = {rem, num_lo[Q_W-1]};
        fits  = (trial >= {1'b0, den_q});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem    <= '0;
            den_q  <= '0;
            num_lo <= '0;
            cnt    <= '0;
            quot   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Upper bits seed the partial remainder; only the low Q_W bits need iterating.
                rem    <= DEN_W'(num >> Q_W);
                num_lo <= num[Q_W-1:0];
                den_q  <= den;
                cnt    <= CNT_W'(Q_W);
            end else if (cnt != '0) begin
                rem    <= fits ? DEN_W'(trial - {1'b0, den_q}) : DEN_W'(trial);
                num_lo <= num_lo << 1;
                quot   <= {quot[Q_W-2:0], fits};
                cnt    <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fx_compressor_mc.sv
// Multi-channel feed-forward compressor: linked peak detect, envelope, divider gain, serial apply.
// Optional makeup gain stage (extra makeup port) enabled by defining FX_COMP_MAKEUP_EN.
module fx_compressor_mc
    import fx_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PARAM_W = 7,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned GAIN_W  = DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    fx_compressor_mc_if.slave  bus,
    input  logic [PARAM_W-1:0] threshold,
    input  logic [PARAM_W-1:0] ratio,
    input  logic [PARAM_W-1:0] attack,
    input  logic [PARAM_W-1:0] release_time,
`ifdef FX_COMP_MAKEUP_EN
    input  logic [PARAM_W-1:0] makeup,
`endif
    output logic [GAIN_W-1:0]  gain,
    output logic               overrun
);
    localparam int unsigned ENV_W = DATA_W - 1;
    localparam int unsigned NUM_W = ENV_W + GAIN_W - 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [GAIN_W-1:0] G_ONE = GAIN_W'(gain_one(GAIN_W));

    state_t                        state;
    logic [NUM_CH-1:0][DATA_W-1:0] x_q;
    logic [NUM_CH-1:0][DATA_W-1:0] stage;
    logic [PARAM_W-1:0]            threshold_q, ratio_q, attack_q, release_q;
    logic [ENV_W-1:0]              peak_q, env;
    logic                          below;
    logic [GAIN_W-1:0]             g_q;
    logic [CH_W-1:0]               ch_idx;
    logic [GAIN_W-1:0]             div_q;
    logic                          div_done;

    logic [ENV_W-1:0]              mag_c, peak_c, env_next, thr_c, target_c;
    logic [3:0]                    a_sh, r_sh;
    logic [2:0]                    ratio_sh;
    logic signed [DATA_W+GAIN_W:0] prod_c;
    logic signed [DATA_W-1:0]      y_c;
    logic [NUM_CH-1:0][DATA_W-1:0] stage_c;

    always_comb begin
        mag_c  = '0;
        peak_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mag_c = ENV_W'(sat_abs(longint'($signed(x_q[i])), DATA_W));
            if (mag_c > peak_c) begin
                peak_c = mag_c;
            end
        end
        a_sh     = ar_shift(32'(attack_q), PARAM_W);
        r_sh     = ar_shift(32'(release_q), PARAM_W);
        ratio_sh = ratio_shift(32'(ratio_q), PARAM_W);
        thr_c    = ENV_W'(thr_scale(32'(threshold_q), PARAM_W, DATA_W));
        env_next = (peak_q > env) ? env + ((peak_q - env) >> a_sh)
                                  : env - ((env - peak_q) >> r_sh);
        // Only meaningful when env_next > thr_c; otherwise the gain is forced to unity.
        target_c = thr_c + ((env_next - thr_c) >> ratio_sh);
    end

`ifdef FX_COMP_MAKEUP_EN
    localparam logic signed [DATA_W+2:0] Y_MAX = (DATA_W+3)'((64'd1 << (DATA_W - 1)) - 64'd1);
    localparam logic signed [DATA_W+2:0] Y_MIN = (DATA_W+3)'(-(longint'(1) << (DATA_W - 1)));
    logic [PARAM_W-1:0]       makeup_q;
    logic [1:0]               m_sh_c;
    logic signed [DATA_W+2:0] yw_c;
`endif

    always_comb begin
        prod_c = (DATA_W+GAIN_W+1)'($signed(x_q[ch_idx])) * (DATA_W+GAIN_W+1)'($signed({1'b0, g_q}));
`ifdef FX_COMP_MAKEUP_EN
        m_sh_c = 2'(makeup_q >> (PARAM_W - 2));
        yw_c   = (DATA_W+3)'(prod_c >>> (GAIN_W - 1)) <<< m_sh_c;
        if (yw_c > Y_MAX) begin
            y_c = DATA_W'(Y_MAX);
        end else if (yw_c < Y_MIN) begin
            y_c = DATA_W'(Y_MIN);
        end else begin
            y_c = DATA_W'(yw_c);
        end
`else
        y_c = DATA_W'(prod_c >>> (GAIN_W - 1));
`endif
        stage_c         = stage;
        stage_c[ch_idx] = y_c;
    end

    fx_udiv #(.NUM_W(NUM_W), .DEN_W(ENV_W), .Q_W(GAIN_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .start (state == S_ENV),
        .num   ({target_c, {(GAIN_W-1){1'b0}}}),
        .den   (env_next),
        .quot  (div_q),
        .done  (div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            x_q           <= '0;
            stage         <= '0;
            threshold_q   <= '0;
            ratio_q       <= '0;
            attack_q      <= '0;
            release_q     <= '0;
`ifdef FX_COMP_MAKEUP_EN
            makeup_q      <= '0;
`endif
            peak_q        <= '0;
            env           <= '0;
            below         <= 1'b1;
            g_q           <= G_ONE;
            ch_idx        <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.audio_out <= '0;
            gain          <= G_ONE;
            overrun       <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_q         <= bus.audio_in;
                        threshold_q <= threshold;
                        ratio_q     <= ratio;
                        attack_q    <= attack;
                        release_q   <= release_time;
`ifdef FX_COMP_MAKEUP_EN
                        makeup_q    <= makeup;
`endif
                        bus.busy    <= 1'b1;
                        state       <= S_DETECT;
                    end
                end
                S_DETECT: begin
                    peak_q <= peak_c;
                    state  <= S_ENV;
                end
                S_ENV: begin
                    env   <= env_next;
                    below <= (env_next <= thr_c);
                    state <= S_DIV;
                end
                S_DIV: begin
                    if (div_done) begin
                        g_q    <= below ? G_ONE : ((div_q > G_ONE) ? G_ONE : div_q);
                        ch_idx <= '0;
                        state  <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    stage <= stage_c;
                    if (ch_idx == CH_W'(NUM_CH - 1)) begin
                        bus.audio_out <= stage_c;
                        gain          <= g_q;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        ch_idx <= ch_idx + CH_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx_compressor_mc.sv
// Scoreboard bench for fx_compressor_mc: reference model per accepted frame, checked at out_valid.
module tb_fx_compressor_mc;
    localparam int DATA_W  = 16;
    localparam int PARAM_W = 7;
    localparam int NUM_CH  = 2;
    localparam int GAIN_W  = 16;
    localparam int LAT     = GAIN_W + NUM_CH + 3;
    localparam int ONE     = 1 << (GAIN_W - 1);
    localparam int SMAX    = (1 << (DATA_W - 1)) - 1;

    typedef struct packed {
        logic [NUM_CH-1:0][DATA_W-1:0] y;
        logic [GAIN_W-1:0]             g;
        logic [DATA_W-2:0]             env;
        int                            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [PARAM_W-1:0] threshold, ratio, attack, release_time;
`ifdef FX_COMP_MAKEUP_EN
    logic [PARAM_W-1:0] makeup;
`endif
    logic [GAIN_W-1:0] gain;
    logic overrun;

    always #5 clk = ~clk;

    fx_compressor_mc_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    fx_compressor_mc #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .NUM_CH(NUM_CH), .GAIN_W(GAIN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .threshold    (threshold),
        .ratio        (ratio),
        .attack       (attack),
        .release_time (release_time),
`ifdef FX_COMP_MAKEUP_EN
        .makeup       (makeup),
`endif
        .gain         (gain),
        .overrun      (overrun)
    );

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int free_at = 0;
    int m_env = 0;
    int n_acc = 0;
    int n_ov = 0;
    bit m_ovr = 1'b0;
    logic [NUM_CH-1:0][DATA_W-1:0] last_y = '0;
    int last_g = ONE;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [NUM_CH-1:0][DATA_W-1:0] x,
                                   input int thr_k, input int rat_k, input int att_k, input int rel_k);
        exp_t e;
        int peak, a, thr, tgt;
        longint g, y;
        peak = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            a = int'($signed(x[ch]));
            if (a < 0) a = -a;
            if (a > SMAX) a = SMAX;
            if (a > peak) peak = a;
        end
        if (peak > m_env) m_env = m_env + ((peak - m_env) >> (att_k >> (PARAM_W - 4)));
        else              m_env = m_env - ((m_env - peak) >> (rel_k >> (PARAM_W - 4)));
        thr = thr_k << (DATA_W - 1 - PARAM_W);
        if (m_env <= thr) begin
            g = longint'(ONE);
        end else begin
            tgt = thr + ((m_env - thr) >> (rat_k >> (PARAM_W - 3)));
            g = (longint'(tgt) << (GAIN_W - 1)) / longint'(m_env);
            if (g > longint'(ONE)) g = longint'(ONE);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            y = (longint'($signed(x[ch])) * g) >>> (GAIN_W - 1);
            e.y[ch] = DATA_W'(y);
        end
        e.g   = GAIN_W'(g);
        e.env = (DATA_W-1)'(m_env);
        e.due = 0;
        return e;
    endfunction

    // One clock: model acceptance/reset at the edge, then sample and score DUT outputs.
    task automatic step();
        exp_t e;
        bit exp_ov;
        @(posedge clk);
        cyc++;
        if (reset) begin
            sb.delete();
            m_env = 0; free_at = 0; m_ovr = 1'b0; last_y = '0; last_g = ONE;
        end else if (bus.in_valid) begin
            if (cyc >= free_at) begin
                e = model(bus.audio_in, int'(threshold), int'(ratio), int'(attack), int'(release_time));
                e.due = cyc + LAT;
                sb.push_back(e);
                free_at = cyc + LAT + 1;
                n_acc++;
            end else begin
                m_ovr = 1'b1;
            end
        end
        #1;
        exp_ov = (sb.size() != 0) && (sb[0].due == cyc);
        check("out_valid", longint'(bus.out_valid), longint'(exp_ov));
        if (bus.out_valid) n_ov++;
        if (exp_ov) begin
            e = sb.pop_front();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                check($sformatf("audio_out[%0d]", ch), longint'($signed(bus.audio_out[ch])),
                      longint'($signed(e.y[ch])));
            end
            check("gain", longint'(gain), longint'(e.g));
            check("env", longint'(dut.env), longint'(e.env));
            last_y = e.y;
            last_g = int'(e.g);
        end
        check("busy", longint'(bus.busy), longint'(sb.size() != 0));
        check("overrun", longint'(overrun), longint'(m_ovr));
        check("hold_audio_out", longint'(bus.audio_out), longint'(last_y));
        check("hold_gain", longint'(gain), longint'(last_g));
    endtask

    task automatic send(input int l, input int r, input int thr, input int rat, input int att, input int rel);
        bus.audio_in = {DATA_W'(r), DATA_W'(l)};
        threshold = PARAM_W'(thr);
        ratio = PARAM_W'(rat);
        attack = PARAM_W'(att);
        release_time = PARAM_W'(rel);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (LAT + 1) step();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.audio_in = '0;
        threshold = '0; ratio = '0; attack = '0; release_time = '0;
`ifdef FX_COMP_MAKEUP_EN
        makeup = '0;
`endif
        repeat (3) step();
        reset = 1'b0;
        step();
        check("env_reset", longint'(dut.env), 0);

        // Below threshold: unity gain, exact latency checked by the scoreboard.
        send(1000, -1000, 127, 0, 0, 0);
        check("below_L", longint'($signed(bus.audio_out[0])), 1000);
        check("below_gain", longint'(gain), 32768);

        // Hard compression, then linked detection with the saturating negative full-scale.
        send(32767, 0, 64, 127, 0, 0);
        check("hard_gain", longint'(gain), 16511);
        check("hard_L", longint'($signed(bus.audio_out[0])), 16510);
        send(0, -32768, 64, 127, 0, 0);
        check("linked_R", longint'($signed(bus.audio_out[1])), -16511);
        check("linked_gain", longint'(gain), 16511);

        // Release: envelope halves each silent frame.
        send(32767, 0, 127, 0, 0, 8);
        check("rel_env0", longint'(dut.env), 32767);
        send(0, 0, 127, 0, 0, 8);
        check("rel_env1", longint'(dut.env), 16384);
        send(0, 0, 127, 0, 0, 8);
        check("rel_env2", longint'(dut.env), 8192);
        send(0, 0, 127, 0, 0, 8);
        check("rel_env3", longint'(dut.env), 4096);

        for (int i = 0; i < 6; i++) begin
            send(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(127)), int'($urandom_range(127)),
                 int'($urandom_range(127)), int'($urandom_range(127)));
        end

        // Strobe held high: only strobes landing in idle cycles are accepted.
        n_acc = 0; n_ov = 0;
        threshold = 7'd40; ratio = 7'd80; attack = 7'd20; release_time = 7'd30;
        bus.in_valid = 1'b1;
        repeat (70) begin
            bus.audio_in = {DATA_W'($urandom), DATA_W'($urandom)};
            step();
        end
        bus.in_valid = 1'b0;
        repeat (LAT + 2) step();
        check("ov_count", longint'(n_ov), longint'(n_acc));
        check("overrun_sticky", longint'(overrun), 1);

        // Reset pulse while the divider is running aborts the frame.
        bus.audio_in = {DATA_W'(5000), DATA_W'(-20000)};
        threshold = 7'd10; ratio = 7'd127; attack = '0; release_time = '0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_env", longint'(dut.env), 0);
        check("abort_gain", longint'(gain), 32768);
        repeat (LAT + 5) step();
        send(1000, -1000, 127, 0, 0, 0);
        check("post_reset_env", longint'(dut.env), 1000);
        check("post_reset_R", longint'($signed(bus.audio_out[1])), -1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
